// File: rtl/instr_cycle_controller.sv
// Instruction-cycle sequencer: steps T1..T6 and decodes the opcode into datapath control strobes.
// Define JMP_INSTR_EN to decode JMP (0011); otherwise it is a NOP and pc_load stays 0.
module instr_cycle_controller #(
    parameter int OPCODE_W = 4,
    parameter int TSTATE_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pc_enable,
    output logic                pc_out,
    output logic                pc_load,
    output logic                mar_load,
    output logic                mem_out,
    output logic                ir_load,
    output logic                ir_out,
    output logic                a_load,
    output logic                a_out,
    output logic                b_load,
    output logic                alu_out,
    output logic                alu_sub,
    output logic                out_load,
    output logic                halted,
    output logic [TSTATE_W-1:0] t_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_T5   = 3'd5,
        S_T6   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'b0000);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'b0001);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'b0010);
`ifdef JMP_INSTR_EN
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'b0011);
`endif
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'b1110);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'b1111);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (run) state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = S_T4;
            S_T4:    state_d = (opcode == OP_HLT) ? S_HALT : S_T5;
            S_T5:    state_d = S_T6;
            S_T6:    state_d = run ? S_T1 : S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are pure decodes of the current state so each is high exactly during its T-state.
    always_comb begin
        pc_enable = 1'b0;
        pc_out    = 1'b0;
        pc_load   = 1'b0;
        mar_load  = 1'b0;
        mem_out   = 1'b0;
        ir_load   = 1'b0;
        ir_out    = 1'b0;
        a_load    = 1'b0;
        a_out     = 1'b0;
        b_load    = 1'b0;
        alu_out   = 1'b0;
        alu_sub   = 1'b0;
        out_load  = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_T1: begin
                pc_out   = 1'b1;
                mar_load = 1'b1;
            end
            S_T2: pc_enable = 1'b1;
            S_T3: begin
                mem_out = 1'b1;
                ir_load = 1'b1;
            end
            S_T4: begin
                if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                    ir_out   = 1'b1;
                    mar_load = 1'b1;
                end
`ifdef JMP_INSTR_EN
                if (opcode == OP_JMP) begin
                    ir_out  = 1'b1;
                    pc_load = 1'b1;
                end
`endif
                if (opcode == OP_OUT) begin
                    a_out    = 1'b1;
                    out_load = 1'b1;
                end
            end
            S_T5: begin
                if (opcode == OP_LDA) begin
                    mem_out = 1'b1;
                    a_load  = 1'b1;
                end
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    mem_out = 1'b1;
                    b_load  = 1'b1;
                    alu_sub = (opcode == OP_SUB);
                end
            end
            S_T6: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    alu_out = 1'b1;
                    a_load  = 1'b1;
                    alu_sub = (opcode == OP_SUB);
                end
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign t_state = TSTATE_W'(state_q);

endmodule

// File: tb/tb_instr_cycle_controller.sv
// Bench for instr_cycle_controller: directed literal checks plus randomized run against a T-index model.
module tb_instr_cycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [3:0] opcode;
    logic       pc_enable, pc_out, pc_load, mar_load, mem_out, ir_load, ir_out;
    logic       a_load, a_out, b_load, alu_out, alu_sub, out_load, halted;
    logic [2:0] t_state;

    always #5 clk = ~clk;

    instr_cycle_controller #(.OPCODE_W(4), .TSTATE_W(3)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .pc_enable(pc_enable), .pc_out(pc_out), .pc_load(pc_load),
        .mar_load(mar_load), .mem_out(mem_out), .ir_load(ir_load),
        .ir_out(ir_out), .a_load(a_load), .a_out(a_out), .b_load(b_load),
        .alu_out(alu_out), .alu_sub(alu_sub), .out_load(out_load),
        .halted(halted), .t_state(t_state)
    );

`ifdef JMP_INSTR_EN
    localparam bit JMP_EN = 1'b1;
`else
    localparam bit JMP_EN = 1'b0;
`endif

    localparam logic [13:0] PCEN = 14'h2000, PCO = 14'h1000, PCL = 14'h0800, MARL = 14'h0400;
    localparam logic [13:0] MEMO = 14'h0200, IRL = 14'h0100, IRO = 14'h0080, AL = 14'h0040;
    localparam logic [13:0] AO = 14'h0020, BL = 14'h0010, ALUO = 14'h0008, SUB = 14'h0004;
    localparam logic [13:0] OUTL = 14'h0002, HLTD = 14'h0001;

    logic [13:0] dut_vec;
    assign dut_vec = {pc_enable, pc_out, pc_load, mar_load, mem_out, ir_load, ir_out,
                      a_load, a_out, b_load, alu_out, alu_sub, out_load, halted};

    int n_cmp = 0;
    int n_bad = 0;
    int m_t   = 0;   // model position: 0 idle, 1..6 T-states, 7 halted
    bit chk_en = 1'b0;

    function automatic logic [13:0] exp_vec(input int t, input logic [3:0] op);
        case (t)
            1: return PCO | MARL;
            2: return PCEN;
            3: return MEMO | IRL;
            4: case (op)
                   4'h0, 4'h1, 4'h2: return IRO | MARL;
                   4'h3:             return JMP_EN ? (IRO | PCL) : 14'h0;
                   4'hE:             return AO | OUTL;
                   default:          return 14'h0;
               endcase
            5: case (op)
                   4'h0:    return MEMO | AL;
                   4'h1:    return MEMO | BL;
                   4'h2:    return MEMO | BL | SUB;
                   default: return 14'h0;
               endcase
            6: case (op)
                   4'h1:    return ALUO | AL;
                   4'h2:    return ALUO | AL | SUB;
                   default: return 14'h0;
               endcase
            7: return HLTD;
            default: return 14'h0;
        endcase
    endfunction

    function automatic int next_t(input int t, input logic r, input logic ru, input logic [3:0] op);
        if (!r)                   return 0;
        if (t == 7)               return 7;
        if (t == 0)               return ru ? 1 : 0;
        if (t == 4 && op == 4'hF) return 7;
        if (t == 6)               return ru ? 1 : 0;
        return t + 1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic [13:0] ev;
            ev = exp_vec(m_t, opcode);
            n_cmp++;
            if (dut_vec !== ev || t_state !== 3'(m_t)) begin
                n_bad++;
                $display("FAIL model_cycle t=%0d op=%h: got t_state=%0d ctrl=%b, expected t_state=%0d ctrl=%b",
                         m_t, opcode, t_state, dut_vec, m_t, ev);
            end
        end
    end

    task automatic tick(input logic r, input logic ru, input logic [3:0] op);
        rst = r;
        run = ru;
        opcode = op;
        @(posedge clk);
        m_t = next_t(m_t, rst, run, opcode);
        #1;
    endtask

    task automatic check_lit(input string name, input int et, input logic [13:0] ev);
        n_cmp++;
        if (t_state !== 3'(et) || dut_vec !== ev) begin
            n_bad++;
            $display("FAIL %s: got t_state=%0d ctrl=%b, expected t_state=%0d ctrl=%b",
                     name, t_state, dut_vec, et, ev);
        end
    endtask

    initial begin
        tick(1'b0, 1'b1, 4'h1);
        chk_en = 1'b1;
        tick(1'b0, 1'b1, 4'h1);
        check_lit("reset_idle", 0, 14'h0);
        tick(1'b1, 1'b1, 4'h1); check_lit("add_t1", 1, PCO | MARL);
        tick(1'b1, 1'b1, 4'h1); check_lit("add_t2", 2, PCEN);
        tick(1'b1, 1'b1, 4'h1); check_lit("add_t3", 3, MEMO | IRL);
        tick(1'b1, 1'b1, 4'h1); check_lit("add_t4", 4, IRO | MARL);
        tick(1'b1, 1'b1, 4'h1); check_lit("add_t5", 5, MEMO | BL);
        tick(1'b1, 1'b1, 4'h1); check_lit("add_t6", 6, ALUO | AL);
        tick(1'b1, 1'b1, 4'h2); check_lit("add_back_t1", 1, PCO | MARL);

        tick(1'b1, 1'b1, 4'h2);
        tick(1'b1, 1'b1, 4'h2);
        tick(1'b1, 1'b1, 4'h2); check_lit("sub_t4", 4, IRO | MARL);
        tick(1'b1, 1'b1, 4'h2); check_lit("sub_t5", 5, MEMO | BL | SUB);
        tick(1'b1, 1'b1, 4'h2); check_lit("sub_t6", 6, ALUO | AL | SUB);

        tick(1'b1, 1'b1, 4'hF); check_lit("hlt_t1", 1, PCO | MARL);
        tick(1'b1, 1'b1, 4'hF);
        tick(1'b1, 1'b1, 4'hF);
        tick(1'b1, 1'b1, 4'hF); check_lit("hlt_t4", 4, 14'h0);
        tick(1'b1, 1'b1, 4'hF); check_lit("hlt_enter", 7, HLTD);
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'((i >> 0) & 1), 4'($urandom_range(0, 15)));
            check_lit("hlt_hold", 7, HLTD);
        end
        tick(1'b0, 1'b1, 4'h0); check_lit("hlt_reset", 0, 14'h0);

        tick(1'b1, 1'b1, 4'h0); check_lit("lda_t1", 1, PCO | MARL);
        tick(1'b1, 1'b1, 4'h0);
        tick(1'b1, 1'b0, 4'h0); check_lit("run_drop_t3", 3, MEMO | IRL);
        tick(1'b1, 1'b0, 4'h0); check_lit("lda_t4", 4, IRO | MARL);
        tick(1'b1, 1'b0, 4'h0); check_lit("lda_t5", 5, MEMO | AL);
        tick(1'b1, 1'b0, 4'h0); check_lit("lda_t6", 6, 14'h0);
        tick(1'b1, 1'b0, 4'h0); check_lit("run_drop_idle", 0, 14'h0);
        tick(1'b1, 1'b0, 4'h0); check_lit("idle_hold", 0, 14'h0);

        tick(1'b1, 1'b1, 4'h1);
        tick(1'b1, 1'b1, 4'h1);
        tick(1'b1, 1'b1, 4'h1);
        tick(1'b1, 1'b1, 4'h1);
        tick(1'b1, 1'b1, 4'h1); check_lit("abort_t5", 5, MEMO | BL);
        tick(1'b0, 1'b1, 4'h1); check_lit("abort_idle", 0, 14'h0);
        tick(1'b1, 1'b0, 4'h1); check_lit("abort_no_aload", 0, 14'h0);

        tick(1'b1, 1'b1, 4'h3);
        tick(1'b1, 1'b1, 4'h3);
        tick(1'b1, 1'b1, 4'h3);
        tick(1'b1, 1'b1, 4'h3); check_lit("jmp_t4", 4, JMP_EN ? (IRO | PCL) : 14'h0);
        tick(1'b1, 1'b1, 4'h3); check_lit("jmp_t5", 5, 14'h0);
        tick(1'b1, 1'b0, 4'h3); check_lit("jmp_t6", 6, 14'h0);
        tick(1'b1, 1'b0, 4'h3); check_lit("jmp_idle", 0, 14'h0);

        for (int i = 0; i < 4000; i++) begin
            logic       r;
            logic       ru;
            logic [3:0] op;
            r  = ($urandom_range(0, 63) != 0);
            ru = ($urandom_range(0, 7) != 0);
            op = opcode;
            if ($urandom_range(0, 3) == 0) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 14));
            end
            tick(r, ru, op);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
